dcache_write_buffer: RTL

Posted-write buffer on the data-side sram-like path between the data cache and the AXI interface bridge. Cache writes are acknowledged as soon as they enter a small FIFO and are drained to the AXI bridge in the background. Reads are held off until the buffer is empty, so a read never overtakes an older write. One downstream transaction is outstanding at a time; ordering of data_ok on both sides is strictly in request order.

---
 rtl/dcache_write_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dcache_write_buffer.sv
// -----------------------------------------------------------------------------
// dcache_write_buffer
// Posted-write buffer between the data cache (sram-like, up_*) and the AXI
// bridge (sram-like, dn_*). Writes are acknowledged the cycle after they enter
// a DEPTH-entry FIFO and drain to the bridge in the background, one
// transaction at a time. A read is accepted only once the FIFO is empty, the
// FSM is idle and no write ack is pending, so reads never pass older writes.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   up_req_i/up_wr_i    cache request, 1 = write / 0 = read
//   up_size_i/addr/wdata request fields (size 0/1/2 = byte/half/word)
//   up_rdata_o          read data, valid with up_data_ok_o on a read
//   up_addr_ok_o        request accepted this cycle
//   up_data_ok_o        request completed this cycle
//   dn_req_o..dn_wdata_o request to the bridge
//   dn_rdata_i          read data from the bridge
//   dn_addr_ok_i        bridge accepted the request
//   dn_data_ok_i        bridge completed the request
//   buf_empty_o         FIFO empty and FSM idle (store-drain fence)
// -----------------------------------------------------------------------------
module dcache_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        up_req_i,
    input  logic        up_wr_i,
    input  logic [1:0]  up_size_i,
    input  logic [31:0] up_addr_i,
    input  logic [31:0] up_wdata_i,
    output logic [31:0] up_rdata_o,
    output logic        up_addr_ok_o,
    output logic        up_data_ok_o,
    output logic        dn_req_o,
    output logic        dn_wr_o,
    output logic [1:0]  dn_size_o,
    output logic [31:0] dn_addr_o,
    output logic [31:0] dn_wdata_o,
    input  logic [31:0] dn_rdata_i,
    input  logic        dn_addr_ok_i,
    input  logic        dn_data_ok_i,
    output logic        buf_empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        R_ADDR = 3'd3,
        R_DATA = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      size_mem [DEPTH];
    logic [31:0]     addr_mem [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            wr_ack_q;
    logic [1:0]      rd_size_q;
    logic [31:0]     rd_addr_q;

    logic full, in_read, wr_accept, rd_accept, pop;

    // Full is judged on the registered count: a pop this cycle frees its
    // slot for a push only from the next cycle on.
    assign full      = (count_q == CW'(DEPTH));
    assign in_read   = (state_q == R_ADDR) || (state_q == R_DATA);
    assign wr_accept = up_req_i & up_wr_i & ~full & ~in_read;
    assign rd_accept = up_req_i & ~up_wr_i & (count_q == '0) &
                       (state_q == IDLE) & ~wr_ack_q;
    assign pop       = (state_q == W_DATA) & dn_data_ok_i;

    assign up_addr_ok_o = wr_accept | rd_accept;
    // Write ack and read completion are mutually exclusive: a read cannot be
    // accepted while a write ack is still pending.
    assign up_data_ok_o = wr_ack_q | ((state_q == R_DATA) & dn_data_ok_i);
    assign buf_empty_o  = (count_q == '0) & (state_q == IDLE);

    // Storage has no reset; validity is carried by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            size_mem[wr_ptr_q] <= up_size_i;
            addr_mem[wr_ptr_q] <= up_addr_i;
            data_mem[wr_ptr_q] <= up_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_ack_q  <= 1'b0;
            rd_size_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= wr_accept;
            count_q  <= count_q + CW'(wr_accept) - CW'(pop);
            if (wr_accept) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)       rd_ptr_q <= rd_ptr_q + PW'(1);
            if (rd_accept) begin
                rd_size_q <= up_size_i;
                rd_addr_q <= up_addr_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dn_req_o   = 1'b0;
        dn_wr_o    = 1'b0;
        dn_size_o  = '0;
        dn_addr_o  = '0;
        dn_wdata_o = '0;
        up_rdata_o = '0;
        case (state_q)
            IDLE: begin
                if (count_q != '0)  state_d = W_ADDR;
                else if (rd_accept) state_d = R_ADDR;
            end
            W_ADDR: begin
                dn_req_o   = 1'b1;
                dn_wr_o    = 1'b1;
                dn_size_o  = size_mem[rd_ptr_q];
                dn_addr_o  = addr_mem[rd_ptr_q];
                dn_wdata_o = data_mem[rd_ptr_q];
                if (dn_addr_ok_i) state_d = W_DATA;
            end
            W_DATA: begin
                if (dn_data_ok_i) state_d = IDLE;
            end
            R_ADDR: begin
                dn_req_o  = 1'b1;
                dn_size_o = rd_size_q;
                dn_addr_o = rd_addr_q;
                if (dn_addr_ok_i) state_d = R_DATA;
            end
            R_DATA: begin
                if (dn_data_ok_i) begin
                    up_rdata_o = dn_rdata_i;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
